// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - shared prescaler feeding NCH programmable periodic/one-shot tick channels
module tick_divider #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int NCH        = 4,
  parameter int PW         = 16,
  parameter int DEF_PERIOD = 1000
) (
  input  logic                                 CLK,
  input  logic                                 RST_N,
  input  logic                                 EN,
  input  logic                                 cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [PW-1:0]                        cfg_period,
  input  logic                                 cfg_mode,
  input  logic [NCH-1:0]                       start,
  input  logic [NCH-1:0]                       stop,
  output logic                                 base_tick,
  output logic [NCH-1:0]                       tick,
  output logic [NCH-1:0]                       toggle,
  output logic [NCH-1:0]                       busy
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("tick_divider: CLK_HZ/TICK_HZ must be at least 2");
  end

  typedef enum logic {IDLE, RUN} ch_state_t;

  logic [PCW-1:0] pcnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcnt      <= '0;
      base_tick <= 1'b0;
    end else if (EN) begin
      base_tick <= (pcnt == PCW'(DIV - 1));
      pcnt      <= (pcnt == PCW'(DIV - 1)) ? '0 : pcnt + PCW'(1);
    end else begin
      base_tick <= 1'b0;
    end
  end

  ch_state_t      st     [NCH];
  ch_state_t      st_n   [NCH];
  logic [PW-1:0]  cnt    [NCH];
  logic [PW-1:0]  cnt_n  [NCH];
  logic [PW-1:0]  cfg_p  [NCH];
  logic           cfg_m  [NCH];
  logic [PW-1:0]  act_p  [NCH];
  logic [PW-1:0]  act_p_n[NCH];
  logic           act_m  [NCH];
  logic           act_m_n[NCH];
  logic [NCH-1:0] tick_n;
  logic [NCH-1:0] toggle_n;

  // Priority per channel: stop, then start/restart, then base-tick counting.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_n[i]     = st[i];
      cnt_n[i]    = cnt[i];
      act_p_n[i]  = act_p[i];
      act_m_n[i]  = act_m[i];
      tick_n[i]   = 1'b0;
      toggle_n[i] = toggle[i];
      case (st[i])
        IDLE: begin
          if (start[i] && !stop[i] && cfg_p[i] != '0) begin
            st_n[i]    = RUN;
            cnt_n[i]   = '0;
            act_p_n[i] = cfg_p[i];
            act_m_n[i] = cfg_m[i];
          end
        end
        RUN: begin
          if (stop[i]) begin
            st_n[i]  = IDLE;
            cnt_n[i] = '0;
          end else if (start[i]) begin
            cnt_n[i]   = '0;
            act_p_n[i] = cfg_p[i];
            act_m_n[i] = cfg_m[i];
            if (cfg_p[i] == '0) st_n[i] = IDLE;
          end else if (base_tick) begin
            if (cnt[i] == act_p[i] - PW'(1)) begin
              tick_n[i]   = 1'b1;
              toggle_n[i] = ~toggle[i];
              cnt_n[i]    = '0;
              if (act_m[i] || cfg_p[i] == '0) begin
                st_n[i] = IDLE;
              end else begin
                act_p_n[i] = cfg_p[i];
                act_m_n[i] = cfg_m[i];
              end
            end else begin
              cnt_n[i] = cnt[i] + PW'(1);
            end
          end
        end
        default: st_n[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NCH; i++) begin
        st[i]    <= IDLE;
        cnt[i]   <= '0;
        act_p[i] <= PW'(DEF_PERIOD);
        act_m[i] <= 1'b0;
      end
      tick   <= '0;
      toggle <= '0;
      busy   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st[i]    <= st_n[i];
        cnt[i]   <= cnt_n[i];
        act_p[i] <= act_p_n[i];
        act_m[i] <= act_m_n[i];
        busy[i]  <= (st_n[i] == RUN);
      end
      tick   <= tick_n;
      toggle <= toggle_n;
    end
  end

  // Shadow config; the channel logic above sees the pre-write value this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NCH; i++) begin
        cfg_p[i] <= PW'(DEF_PERIOD);
        cfg_m[i] <= 1'b0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(cfg_ch) == i) begin
          cfg_p[i] <= cfg_period;
          cfg_m[i] <= cfg_mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_divider.sv
// tb/tb_tick_divider.sv - self-checking bench for tick_divider against a tick-countdown model
module tb_tick_divider;

  localparam int CLK_HZ = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int NCH = 2;
  localparam int PW = 8;
  localparam int DEFP = 25;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic           EN;
  logic           cfg_we;
  logic [0:0]     cfg_ch;
  logic [PW-1:0]  cfg_period;
  logic           cfg_mode;
  logic [NCH-1:0] start, stop;
  logic           base_tick;
  logic [NCH-1:0] tick, toggle, busy;

  int checks = 0;
  int failures = 0;
  bit chk_on = 0;

  tick_divider #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NCH(NCH), .PW(PW), .DEF_PERIOD(DEFP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_mode(cfg_mode), .start(start), .stop(stop),
    .base_tick(base_tick), .tick(tick), .toggle(toggle), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Model: enabled-edge count for the prescaler, remaining-ticks countdown per channel.
  int             edge_cnt, en_cnt;
  int             m_rem[NCH];
  int             m_sp[NCH];
  bit             m_sm[NCH];
  bit             m_am[NCH];
  logic           m_bt;
  logic [NCH-1:0] m_run, m_tick, m_tog;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      edge_cnt = 0; en_cnt = 0; m_bt = 0;
      m_run = '0; m_tick = '0; m_tog = '0;
      for (int i = 0; i < NCH; i++) begin
        m_rem[i] = 0; m_sp[i] = DEFP; m_sm[i] = 0; m_am[i] = 0;
      end
    end else begin
      edge_cnt++;
      for (int i = 0; i < NCH; i++) begin
        m_tick[i] = 0;
        if (stop[i]) m_run[i] = 0;
        else if (start[i]) begin
          if (m_sp[i] != 0) begin
            m_run[i] = 1; m_rem[i] = m_sp[i]; m_am[i] = m_sm[i];
          end else m_run[i] = 0;
        end else if (m_run[i] && m_bt) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_tick[i] = 1;
            m_tog[i] = ~m_tog[i];
            if (m_am[i] || m_sp[i] == 0) m_run[i] = 0;
            else begin
              m_rem[i] = m_sp[i]; m_am[i] = m_sm[i];
            end
          end
        end
      end
      if (cfg_we && int'(cfg_ch) < NCH) begin
        m_sp[cfg_ch] = int'(cfg_period);
        m_sm[cfg_ch] = cfg_mode;
      end
      m_bt = EN && (en_cnt % DIV == DIV - 1);
      if (EN) en_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      check("model_base_tick", int'(base_tick), int'(m_bt));
      check("model_tick", int'(tick), int'(m_tick));
      check("model_toggle", int'(toggle), int'(m_tog));
      check("model_busy", int'(busy), int'(m_run));
    end
  end

  task automatic wait_bt(input int lim, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge CLK);
      if (base_tick) begin at = edge_cnt; break; end
    end
  endtask

  task automatic wait_tick(input int ch, input int lim, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge CLK);
      if (tick[ch]) begin at = edge_cnt; break; end
    end
  endtask

  task automatic cfg_write(input int ch, input int p, input bit m);
    cfg_we = 1; cfg_ch = 1'(ch); cfg_period = PW'(p); cfg_mode = m;
    @(negedge CLK);
    cfg_we = 0;
  endtask

  task automatic pulse(input logic [NCH-1:0] s, input logic [NCH-1:0] p);
    start = s; stop = p;
    @(negedge CLK);
    start = '0; stop = '0;
  endtask

  int a, b, c, d, e, n;

  initial begin
    RST_N = 0; EN = 1; cfg_we = 0; cfg_ch = '0; cfg_period = '0; cfg_mode = 0;
    start = '0; stop = '0;
    repeat (3) @(negedge CLK);
    chk_on = 1;
    check("reset_busy", int'(busy), 0);
    check("reset_toggle", int'(toggle), 0);
    RST_N = 1;

    wait_bt(50, a); check("first_base_tick_edge", a, 10);
    wait_bt(50, b); check("second_base_tick_edge", b, 20);
    EN = 0;
    repeat (5) @(negedge CLK);
    EN = 1;
    wait_bt(50, c); check("base_tick_after_en_gap", c, 35);

    cfg_write(0, 3, 0);
    pulse(2'b01, 2'b00);
    wait_tick(0, 100, a); check("per_tog1", int'(toggle[0]), 1); check("per_busy", int'(busy[0]), 1);
    wait_tick(0, 100, b); check("per_tog2", int'(toggle[0]), 0);
    wait_tick(0, 100, c); check("per_tog3", int'(toggle[0]), 1);
    check("per_space1", b - a, 30);
    check("per_space2", c - b, 30);

    cfg_write(1, 2, 1);
    pulse(2'b10, 2'b00);
    wait_tick(1, 100, a);
    check("os_tick_seen", int'(a > 0), 1);
    check("os_busy_drop", int'(busy[1]), 0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (tick[1]) n++;
    end
    check("os_no_more_ticks", n, 0);
    check("os_toggle_hold", int'(toggle[1]), 1);

    wait_tick(0, 100, a);
    wait_bt(20, b);
    cfg_write(0, 5, 0);
    wait_tick(0, 100, c); check("reconf_cur", c - a, 30);
    wait_tick(0, 100, d); check("reconf_next", d - c, 50);
    wait_tick(0, 100, e); check("reconf_next2", e - d, 50);

    pulse(2'b00, 2'b01);
    pulse(2'b01, 2'b01);
    @(negedge CLK);
    check("start_stop_same", int'(busy[0]), 0);
    cfg_write(0, 0, 0);
    pulse(2'b01, 2'b00);
    check("start_period0", int'(busy[0]), 0);

    cfg_write(0, 2, 0);
    pulse(2'b01, 2'b00);
    wait_tick(0, 60, a);
    repeat (19) @(negedge CLK);
    check("bt_at_stop", int'(base_tick), 1);
    pulse(2'b00, 2'b01);
    wait_tick(0, 40, b); check("stop_at_expiry_no_tick", b, -1);
    check("stop_at_expiry_busy", int'(busy[0]), 0);

    wait_bt(20, a);
    pulse(2'b01, 2'b00);
    wait_tick(0, 60, b); check("start_on_bt_full_period", b - a, 21);

    cfg_write(1, 4, 0);
    pulse(2'b10, 2'b00);
    repeat (25) @(negedge CLK);
    #2 RST_N = 0;
    #1;
    check("async_rst_base_tick", int'(base_tick), 0);
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_toggle", int'(toggle), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    check("post_rst_idle", int'(busy), 0);
    pulse(2'b01, 2'b00);
    wait_tick(0, 400, a); check("def_period_tick_edge", a, DEFP * DIV + 1);

    for (int k = 0; k < 3000; k++) begin
      EN = ($urandom_range(0, 9) != 0);
      cfg_we = ($urandom_range(0, 14) == 0);
      cfg_ch = 1'($urandom_range(0, 1));
      cfg_period = PW'($urandom_range(0, 5));
      cfg_mode = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NCH; i++) begin
        start[i] = ($urandom_range(0, 19) == 0);
        stop[i] = ($urandom_range(0, 39) == 0);
      end
      @(negedge CLK);
    end
    EN = 1; cfg_we = 0; start = '0; stop = '0;
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
